// File: rtl/noise_inj_pkg.sv
// Shared state encoding and lane arithmetic helpers for the noise table injector.
// NOISE_INJ_SAT_EN adds a saturating adder; without it lanes wrap in two's complement.
package noise_inj_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2,
        READY = 2'd3
    } state_t;

`ifdef NOISE_INJ_SAT_EN
    function automatic int sat_add(input int a, input int b, input int w);
        int s;
        int hi;
        int lo;
        s  = a + b;
        hi = (1 << (w - 1)) - 1;
        lo = -(1 << (w - 1));
        if (s > hi) return hi;
        if (s < lo) return lo;
        return s;
    endfunction
`endif

endpackage

// File: rtl/noise_lane_add.sv
// Single signed lane adder, purely combinational, no flow control.
// NOISE_INJ_SAT_EN selects clamping to the signed range; otherwise the sum wraps.
module noise_lane_add #(
    parameter int SAMPLE_W = 8
) (
    input  logic [SAMPLE_W-1:0] a_i,
    input  logic [SAMPLE_W-1:0] b_i,
    output logic [SAMPLE_W-1:0] sum_o
);

`ifdef NOISE_INJ_SAT_EN
    assign sum_o = SAMPLE_W'(noise_inj_pkg::sat_add(int'($signed(a_i)), int'($signed(b_i)), SAMPLE_W));
`else
    // Low SAMPLE_W bits of the widened sum are exactly the wrapped result.
    assign sum_o = a_i + b_i;
`endif

endmodule

// File: rtl/noise_table_injector.sv
// Loads a noise table from a wide memory read port, then adds table noise to N_CH lanes with 1-cycle latency.
// No backpressure: valid-only stream; NOISE_INJ_SAT_EN selects saturating instead of wrapping lane sums.
module noise_table_injector
    import noise_inj_pkg::*;
#(
    parameter int SAMPLE_W  = 8,
    parameter int MEM_W     = 64,
    parameter int DEPTH     = 128,
    parameter int N_CH      = 1,
    parameter int ADDR_W    = 14,
    parameter int ADDR_STEP = 4,
    parameter int MEM_LAT   = 1
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     load_start,
    input  logic [ADDR_W-1:0]        base_addr,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic                     mem_rd,
    input  logic [MEM_W-1:0]         mem_rdata,
    output logic                     load_done,
    input  logic                     en,
    input  logic [N_CH*SAMPLE_W-1:0] noise_in,
    input  logic                     noise_in_valid,
    output logic [N_CH*SAMPLE_W-1:0] noise_out,
    output logic                     noise_out_valid
);

    localparam int SPW    = MEM_W / SAMPLE_W;
    localparam int NW     = DEPTH / SPW;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int WCNT_W = $clog2(NW + 1);
    localparam int LW     = N_CH * SAMPLE_W;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic                mem_rd_q, mem_rd_d;
    logic [WCNT_W-1:0]   rd_cnt_q, rd_cnt_d;
    logic [WCNT_W-1:0]   wr_cnt_q, wr_cnt_d;
    logic [MEM_LAT-1:0]  vld_sr_q, vld_sr_d;
    logic                load_done_q, load_done_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [LW-1:0]       noise_out_q, noise_out_d;
    logic                noise_out_valid_q;
    logic                capture;
    logic                add_en;
    logic                last_word;

    logic [SAMPLE_W-1:0] table_q [DEPTH];

    // A return is only taken while a load is live; restarts discard anything in flight.
    assign capture   = vld_sr_q[MEM_LAT-1] && !load_start && (state_q == LOAD || state_q == DRAIN);
    assign last_word = (wr_cnt_q == WCNT_W'(NW - 1));
    assign add_en    = en && load_done_q;

    always_comb begin
        state_d     = state_q;
        mem_addr_d  = mem_addr_q;
        mem_rd_d    = 1'b0;
        rd_cnt_d    = rd_cnt_q;
        wr_cnt_d    = wr_cnt_q;
        vld_sr_d    = MEM_LAT'({vld_sr_q, mem_rd_q});
        load_done_d = load_done_q;

        if (capture) begin
            wr_cnt_d = wr_cnt_q + WCNT_W'(1);
            if (last_word) begin
                load_done_d = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
            end
            LOAD: begin
                if (rd_cnt_q != WCNT_W'(NW)) begin
                    mem_rd_d   = 1'b1;
                    mem_addr_d = mem_addr_q + ADDR_W'(ADDR_STEP);
                    rd_cnt_d   = rd_cnt_q + WCNT_W'(1);
                end else begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (capture && last_word) begin
                    state_d = READY;
                end
            end
            READY: begin
            end
            default: state_d = IDLE;
        endcase

        // The first read of a new load is presented on the cycle right after the pulse.
        if (load_start) begin
            state_d     = LOAD;
            mem_rd_d    = 1'b1;
            mem_addr_d  = base_addr;
            rd_cnt_d    = WCNT_W'(1);
            wr_cnt_d    = '0;
            vld_sr_d    = '0;
            load_done_d = 1'b0;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (noise_in_valid && add_en) begin
            ptr_d = ptr_q + PTR_W'(N_CH);
        end
        if (load_start) begin
            ptr_d = '0;
        end
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_lane
        logic [PTR_W-1:0]    idx;
        logic [SAMPLE_W-1:0] sum;

        assign idx = ptr_q + PTR_W'(c);

        noise_lane_add #(
            .SAMPLE_W (SAMPLE_W)
        ) u_add (
            .a_i   (noise_in[c*SAMPLE_W +: SAMPLE_W]),
            .b_i   (table_q[idx]),
            .sum_o (sum)
        );

        assign noise_out_d[c*SAMPLE_W +: SAMPLE_W] = add_en ? sum : noise_in[c*SAMPLE_W +: SAMPLE_W];
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q           <= IDLE;
            mem_addr_q        <= '0;
            mem_rd_q          <= 1'b0;
            rd_cnt_q          <= '0;
            wr_cnt_q          <= '0;
            vld_sr_q          <= '0;
            load_done_q       <= 1'b0;
            ptr_q             <= '0;
            noise_out_q       <= '0;
            noise_out_valid_q <= 1'b0;
        end else begin
            state_q           <= state_d;
            mem_addr_q        <= mem_addr_d;
            mem_rd_q          <= mem_rd_d;
            rd_cnt_q          <= rd_cnt_d;
            wr_cnt_q          <= wr_cnt_d;
            vld_sr_q          <= vld_sr_d;
            load_done_q       <= load_done_d;
            ptr_q             <= ptr_d;
            noise_out_q       <= noise_out_d;
            noise_out_valid_q <= noise_in_valid;
        end
    end

    // Table storage carries no reset; it is only read once a full load has landed.
    always_ff @(posedge clk) begin
        if (capture && rstn) begin
            for (int j = 0; j < SPW; j++) begin
                table_q[PTR_W'(wr_cnt_q) * PTR_W'(SPW) + PTR_W'(j)] <= mem_rdata[j*SAMPLE_W +: SAMPLE_W];
            end
        end
    end

    assign mem_addr        = mem_addr_q;
    assign mem_rd          = mem_rd_q;
    assign load_done       = load_done_q;
    assign noise_out       = noise_out_q;
    assign noise_out_valid = noise_out_valid_q;

endmodule

// File: tb/tb_noise_table_injector.sv
// Scoreboarded random bench for noise_table_injector (two lanes, three-cycle memory latency).
module tb_noise_table_injector;

    localparam int SW    = 8;
    localparam int MW    = 64;
    localparam int DEPTH = 128;
    localparam int NCH   = 2;
    localparam int AW    = 14;
    localparam int STEP  = 4;
    localparam int LAT   = 3;
    localparam int SPWB  = MW / SW;
    localparam int NW    = DEPTH / SPWB;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              load_start = 1'b0;
    logic [AW-1:0]     base_addr = '0;
    logic [AW-1:0]     mem_addr;
    logic              mem_rd;
    logic [MW-1:0]     mem_rdata;
    logic              load_done;
    logic              en = 1'b0;
    logic [NCH*SW-1:0] noise_in = '0;
    logic              noise_in_valid = 1'b0;
    logic [NCH*SW-1:0] noise_out;
    logic              noise_out_valid;

    logic [MW-1:0]     rd_pipe [LAT];
    int                total = 0;
    int                bad = 0;
    int                mem_gen = 0;
    int                tbl [DEPTH];
    bit                model_loaded = 0;
    int                model_ptr = 0;
    logic [NCH*SW-1:0] exp_q [$];

    noise_table_injector #(
        .SAMPLE_W  (SW),
        .MEM_W     (MW),
        .DEPTH     (DEPTH),
        .N_CH      (NCH),
        .ADDR_W    (AW),
        .ADDR_STEP (STEP),
        .MEM_LAT   (LAT)
    ) dut (
        .clk             (clk),
        .rstn            (rstn),
        .load_start      (load_start),
        .base_addr       (base_addr),
        .mem_addr        (mem_addr),
        .mem_rd          (mem_rd),
        .mem_rdata       (mem_rdata),
        .load_done       (load_done),
        .en              (en),
        .noise_in        (noise_in),
        .noise_in_valid  (noise_in_valid),
        .noise_out       (noise_out),
        .noise_out_valid (noise_out_valid)
    );

    always #5 clk = ~clk;

    // Memory image: generation 0 gives word k = {8{k}}, generation 3 is all 100, others hashed.
    function automatic logic [7:0] mbyte(input int g, input int a, input int j);
        if (g == 0) return 8'(a >> 2);
        if (g == 3) return 8'd100;
        return 8'((a * 29 + j * 71 + g * 113) ^ (a >> 5));
    endfunction

    function automatic logic [MW-1:0] mword(input int g, input int a);
        logic [MW-1:0] w;
        for (int j = 0; j < SPWB; j++) w[j*SW +: SW] = mbyte(g, a, j);
        return w;
    endfunction

    always @(posedge clk) begin
        for (int i = LAT - 1; i > 0; i--) rd_pipe[i] <= rd_pipe[i-1];
        rd_pipe[0] <= mem_rd ? mword(mem_gen, int'(mem_addr)) : '0;
    end
    assign mem_rdata = rd_pipe[LAT-1];

    function automatic logic [SW-1:0] lane_exp(input int a, input int t);
        int s;
        s = a + t;
`ifdef NOISE_INJ_SAT_EN
        if (s > 127) s = 127;
        if (s < -128) s = -128;
`endif
        return SW'(s);
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic run_load(input int base, input int gen, input int abort_after);
        int k;
        int last;
        int cyc;
        bit done;
        k = 0; last = 0; cyc = 0; done = 0;
        model_loaded = 0;
        model_ptr = 0;
        mem_gen = gen;
        base_addr = AW'(base);
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        chk("load_done_clear", int'(load_done), 0);
        while (!done && cyc < 300) begin
            if (mem_rd) begin
                chk("mem_addr", int'(mem_addr), (base + k * STEP) % (1 << AW));
                k++;
                last = cyc;
                if (abort_after != 0 && k == abort_after) return;
            end else if (load_done) begin
                done = 1;
                chk("reads_issued", k, NW);
                chk("done_latency", cyc - last, LAT + 1);
            end
            if (!done) begin
                cyc++;
                @(negedge clk);
            end
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL load_timeout: got no load_done after %0d cycles, expected one", cyc);
        end else begin
            for (int w = 0; w < NW; w++)
                for (int j = 0; j < SPWB; j++)
                    tbl[w*SPWB + j] = int'($signed(mbyte(gen, (base + w * STEP) % (1 << AW), j)));
            model_loaded = 1;
        end
    endtask

    task automatic beats(input int n, input int pv, input int pen, input bit use_fixed, input int fixed);
        logic [NCH*SW-1:0] e;
        int a;
        for (int i = 0; i < n; i++) begin
            noise_in_valid = (int'($urandom_range(99)) < pv);
            en = (int'($urandom_range(99)) < pen);
            for (int c = 0; c < NCH; c++)
                noise_in[c*SW +: SW] = use_fixed ? SW'(fixed) : SW'($urandom);
            if (noise_in_valid) begin
                for (int c = 0; c < NCH; c++) begin
                    a = int'($signed(noise_in[c*SW +: SW]));
                    if (en && model_loaded) e[c*SW +: SW] = lane_exp(a, tbl[(model_ptr + c) % DEPTH]);
                    else                    e[c*SW +: SW] = noise_in[c*SW +: SW];
                end
                if (en && model_loaded) model_ptr = (model_ptr + NCH) % DEPTH;
                exp_q.push_back(e);
            end
            @(negedge clk);
        end
        noise_in_valid = 1'b0;
    endtask

    initial begin
        logic [NCH*SW-1:0] e;
        forever begin
            @(negedge clk);
            if (noise_out_valid) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_beat: got output %0h, expected no valid beat", noise_out);
                end else begin
                    e = exp_q.pop_front();
                    chk("noise_out", int'(noise_out), int'(e));
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish, expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_mem_rd", int'(mem_rd), 0);
        chk("rst_mem_addr", int'(mem_addr), 0);
        chk("rst_load_done", int'(load_done), 0);
        chk("rst_out_valid", int'(noise_out_valid), 0);
        chk("rst_noise_out", int'(noise_out), 0);
        rstn = 1'b1;
        @(negedge clk);

        run_load(0, 0, 0);
        beats(130, 100, 100, 1'b1, 10);
        beats(200, 50, 70, 1'b0, 0);

        // Abort after five reads while three are still in flight, then reload across the address wrap.
        run_load(100, 1, 5);
        run_load(16380, 2, 0);
        beats(150, 60, 80, 1'b0, 0);

        run_load(0, 3, 0);
        beats(20, 100, 100, 1'b1, 100);
        beats(20, 80, 100, 1'b1, -100);
        beats(10, 100, 100, 1'b0, 0);

        noise_in_valid = 1'b1;
        en = 1'b1;
        noise_in = NCH*SW'($urandom);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        noise_in_valid = 1'b0;
        model_loaded = 0;
        model_ptr = 0;
        chk("midrun_rst_load_done", int'(load_done), 0);
        chk("midrun_rst_out_valid", int'(noise_out_valid), 0);
        chk("midrun_rst_mem_rd", int'(mem_rd), 0);
        beats(30, 70, 100, 1'b0, 0);

        run_load(40, 4, 0);
        beats(60, 70, 60, 1'b0, 0);

        repeat (5) @(negedge clk);
        chk("scoreboard_drain", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/noise_table_injector.md
Name: noise_table_injector

Overview:
Parametrised successor to the 128-entry noise wrapper. Self-sequences a noise-table load from an on-chip-memory wide read port: it generates addresses, absorbs the read latency and unpacks each word into several samples. Once loaded, it adds table noise to N_CH parallel signed sample lanes per beat. Sits between the PAM symbol/channel model and the receiver model in the SERDES simulation chain.

Parameters:
SAMPLE_W, 8, signed sample and noise width (bits).
MEM_W, 64, memory read-data width; SPW = MEM_W/SAMPLE_W samples per word.
DEPTH, 128, noise table entries; power of 2; DEPTH % SPW == 0 and DEPTH % N_CH == 0.
N_CH, 1, parallel lanes per beat.
ADDR_W, 14, memory address width.
ADDR_STEP, 4, address increment per word read.
MEM_LAT, 1, memory read latency in cycles (>=1).

Ports:
clk  in  1  clock.
rstn  in  1  reset; synchronous, active-low.
load_start  in  1  single-cycle pulse that starts or restarts a table load.
base_addr  in  ADDR_W  first memory address; sampled on load_start.
mem_addr  out  ADDR_W  memory read address.
mem_rd  out  1  read strobe.
mem_rdata  in  MEM_W  read data, valid MEM_LAT cycles after mem_rd.
load_done  out  1  table valid (replaces done_wait).
en  in  1  noise injection enable.
noise_in  in  N_CH*SAMPLE_W  packed signed lanes; lane c at [c*SAMPLE_W +: SAMPLE_W].
noise_in_valid  in  1  input beat valid.
noise_out  out  N_CH*SAMPLE_W  packed signed result.
noise_out_valid  out  1  output beat valid.

Behaviour:
- Reset: state IDLE. mem_addr=0, mem_rd=0, load_done=0, noise_out=0, noise_out_valid=0, rd/wr word counters=0, table pointer=0. Table contents are not reset.
- FSM states:
  - IDLE -> LOAD on load_start.
  - LOAD issues NW=DEPTH/SPW reads on consecutive cycles. mem_addr = base_addr + k*ADDR_STEP, mem_rd=1 for k=0..NW-1. mem_addr wraps modulo 2^ADDR_W.
  - LOAD -> DRAIN after the last issue. DRAIN waits for the last word.
  - DRAIN -> READY once NW words are captured. load_done rises on that cycle's clock edge.
- Capture: an MEM_LAT-deep valid shift register tracks outstanding reads. Captured word k writes table[k*SPW+j] = mem_rdata[j*SAMPLE_W +: SAMPLE_W] for j=0..SPW-1.
- load_start in any state: restart LOAD. load_done and pointer clear next cycle, and in-flight read returns from the aborted load are discarded.
- READY/RUN datapath (1-cycle registered latency):
  - noise_out_valid = noise_in_valid delayed one cycle.
  - If en && load_done: lane c out = noise_in[c] + table[(ptr+c) mod DEPTH]. On each valid beat, ptr <= (ptr+N_CH) mod DEPTH.
  - Otherwise the lanes pass through unchanged and ptr holds.
  - Invalid beats do not advance ptr. The noise_out data on an invalid beat is don't-care but must be registered (no X).
- Arithmetic: sum computed at SAMPLE_W+1 bits, then reduced per Optional Feature.
- Reset mid-load: everything returns to IDLE. load_done=0 until a new load completes.

Optional Feature:
NOISE_INJ_SAT_EN
- Defined: the sum saturates to [-(2^(SAMPLE_W-1)), 2^(SAMPLE_W-1)-1].
- Undefined: two's-complement wrap (low SAMPLE_W bits kept).
- Identical latency either way.

Decomposition:
- Package noise_inj_pkg: state enum (IDLE, LOAD, DRAIN, READY), and a sat_add function guarded by the macro.
- Derived localparams SPW, NW and PTR_W=$clog2(DEPTH) are computed in-module.
- One natural sub-module: noise_lane_add (single-lane adder plus saturate/wrap), instantiated N_CH times with generate.

Test Plan:
1. Defaults, MEM_LAT=1, base_addr=0, memory word k = {8{k[7:0]}} -> mem_addr 0,4,...,60 over 16 cycles. load_done rises 2 cycles after the last issue. table[8k+j]==k.
2. After load, en=1, N_CH=1, noise_in=10 valid for 130 beats -> outputs 10+table[i], index wraps from 127 to 0 on beat 129. Each output lags its input by 1 cycle.
3. N_CH=2, DEPTH=128 -> beat b lanes use table[2b] and table[2b+1]. A gap in noise_in_valid holds ptr.
4. table entry 100, noise_in=100 -> with NOISE_INJ_SAT_EN out=127; without it out=-56.
5. load_start pulsed mid-LOAD after 5 reads, MEM_LAT=3 -> reads restart at base_addr. The stale returns are ignored, verified by distinct data per load, and load_done rises only after 16 new words.
6. rstn low for 1 cycle during RUN -> next cycle load_done=0 and noise_out_valid=0. en=1 then gives pass-through output.
